usr_serial_sequencer: RTL and testbench
=======================================

// Module: usr_serial_sequencer
// PURPOSE
//  Sequences the N-bit universal shift register (usr, ctrl 00 hold / 01 shl / 10 shr / 11 load) as a
//  half-duplex serialiser/deserialiser. The block accepts one job per valid/ready handshake.
//  A TX job loads a word and shifts it out 1 bit per bit-period. An RX job clears the register,
//  shifts N serial bits in, then presents the word. It sits between the word-level control logic
//  and a single-wire serial pin pair.
// PARAMETERS
//  N          8   word width; N>=2
//  BIT_DIV    1   clk cycles per serial bit; BIT_DIV>=1
//  LSB_FIRST  1   1: shift-right ops (10), bit0 first; 0: shift-left ops (01), bit N-1 first
// PORTS
//  clk       in   1  clock, rising edge
//  rst       in   1  asynchronous, active-high reset
//  start     in   1  job request; accepted when start && ready && !abort
//  mode      in   1  0 = TX, 1 = RX; sampled on acceptance
//  tx_word   in   N  TX data; sampled on acceptance
//  abort     in   1  cancel current job; next cycle idle
//  rx_bit    in   1  serial input
//  ready     out  1  high in IDLE
//  tx_bit    out  1  serial output; 1 when not in TX
//  rx_word   out  N  last completed RX word (holds until next RX completion)
//  done      out  1  1-cycle pulse at completion of any job (not on abort)
//  rx_valid  out  1  1-cycle pulse, coincident with done, RX jobs only
// BEHAVIOUR
//  - Reset: state IDLE, usr cleared, div/bit counters 0, rx_word 0, done 0, rx_valid 0, ready 1, tx_bit 1.
//  - Cycle 0 is the acceptance cycle. In that cycle usr ctrl=11:
//    TX: usr_d = tx_word. RX: usr_d = 0. FSM -> TX or RX at the edge.
//  - Bit period: div counts 0..BIT_DIV-1. The last cycle of each period (div==BIT_DIV-1) is the shift
//    cycle; bit_cnt increments there. All other cycles: ctrl=00.
//  - TX: tx_bit = q[0] (LSB_FIRST=1) or q[N-1] (LSB_FIRST=0), combinational from usr q.
//    Shift-cycle op: ctrl=10 with d[N-1]=0, or ctrl=01 with d[0]=0.
//    Bit k is on tx_bit in cycles k*BIT_DIV+1 .. (k+1)*BIT_DIV.
//  - RX: rx_bit is sampled on shift cycles only, in cycles (k+1)*BIT_DIV, k=0..N-1.
//    LSB_FIRST=1: ctrl=10 with d[N-1]=rx_bit, so the first bit lands in rx_word[0].
//    LSB_FIRST=0: ctrl=01 with d[0]=rx_bit, so the first bit lands in rx_word[N-1].
//  - Completion: the shift cycle with bit_cnt==N-1 sends the FSM to IDLE. RX also captures
//    rx_word <= next usr value at that edge. done (and rx_valid for RX) are registered and high
//    in cycle N*BIT_DIV+1, with ready=1 in the same cycle.
//  - Back-to-back: start may be accepted in the done cycle; no idle gap is required.
//  - Busy: start is ignored while ready=0. mode and tx_word are don't-care outside acceptance.
//  - Abort: in TX/RX -> IDLE at the next edge; ctrl=00 in the abort cycle; counters cleared;
//    no done/rx_valid; rx_word unchanged; usr contents left as-is.
//    Abort in IDLE: start is blocked that cycle, otherwise no effect.
//  - Reset mid-job: immediate return to reset values; no done pulse.
//  - Counters: div is $clog2(BIT_DIV) bits (min 1); bit_cnt is $clog2(N) bits. Neither wraps
//    past its terminal value.
// STRUCTURE
//  - Package usr_seq_pkg:
//    state enum {IDLE, TX, RX};
//    USR_HOLD=2'b00, USR_SHL=2'b01, USR_SHR=2'b10, USR_LOAD=2'b11.
//  - One sub-module: an instance of the existing usr (parameter N) driven by internal ctrl/d.
//    FSM, counters and output registers live in this module.
// TESTING (N=8 unless noted)
//  1. BIT_DIV=1, LSB_FIRST=1, TX 8'h01 -> tx_bit=1 in cycle 1, then 0 in cycles 2..8; done in cycle 9.
//  2. LSB_FIRST=0, TX 8'h01 -> tx_bit 0 in cycles 1..7, then 1 in cycle 8; done in cycle 9.
//  3. BIT_DIV=3, RX with rx_bit pattern 1,1,0,1,0,0,1,0 (LSB_FIRST=1) -> rx_word=8'h4B,
//     rx_valid and done in cycle 25.
//  4. TX 8'hA5 with abort in cycle 4 -> ready=1 in cycle 5, tx_bit=1, no done;
//     a following TX 8'h3C completes normally.
//  5. start held high during a TX job -> ignored until done; then re-accepted in the done cycle.
//     Two words are sent with no gap.
//  6. rst asserted mid-RX (cycle 5) -> immediate IDLE, rx_word 0, no rx_valid;
//     next RX job is correct after reset release.

Source files
------------

// File: rtl/usr_seq_pkg.sv
// Shared types and constants for the universal-shift-register serial sequencer.
// Holds the FSM state encoding, the usr control opcodes and a counter-width helper.
package usr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        RX   = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TX   = 2'd1;
    localparam logic [1:0] ST_RX   = 2'd2;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHL  = 2'b01;
    localparam logic [1:0] USR_SHR  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    // A counter that only ever holds 0 still needs one bit.
    function automatic int cnt_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/usr.sv
// N-bit universal shift register: hold, shift-left, shift-right or parallel load.
// The serial fill bit comes from d[0] on a left shift and from d[N-1] on a right shift.
module usr
    import usr_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (ctrl)
                USR_SHL:  q <= {q[N-2:0], d[0]};
                USR_SHR:  q <= {d[N-1], q[N-1:1]};
                USR_LOAD: q <= d;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/usr_serial_sequencer.sv
// Half-duplex serialiser/deserialiser built around one universal shift register.
// One job (TX or RX) is accepted per start/ready handshake; done pulses when it completes.
module usr_serial_sequencer
    import usr_seq_pkg::*;
#(
    parameter int N         = 8,
    parameter int BIT_DIV   = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] tx_word,
    input  logic         abort,
    input  logic         rx_bit,
    output logic         ready,
    output logic         tx_bit,
    output logic [N-1:0] rx_word,
    output logic         done,
    output logic         rx_valid,
    output logic [1:0]   state_dbg
);

    localparam int DW = cnt_w(BIT_DIV);
    localparam int BW = $clog2(N);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam bit LSB = (LSB_FIRST != 0);

    logic [1:0]    state, state_nx;
    logic [DW-1:0] div;
    logic [BW-1:0] bit_cnt;
    logic [1:0]    ctrl;
    logic [N-1:0]  usr_d, q, rx_shifted;
    logic          busy, accept, shift, last, in_bit;

    // Handshake: a job is taken in any cycle where start && ready && !abort;
    // ready is high exactly while idle, including the cycle done pulses.
    assign busy   = (state != ST_IDLE);
    assign accept = ready && start && !abort;
    assign shift  = busy && !abort && (div == DIV_LAST);
    assign last   = shift && (bit_cnt == BIT_LAST);
    assign in_bit = (state == ST_RX) ? rx_bit : 1'b0;

    assign rx_shifted = LSB ? {in_bit, q[N-1:1]} : {q[N-2:0], in_bit};

    assign ready     = (state == ST_IDLE);
    assign tx_bit    = (state == ST_TX) ? (LSB ? q[0] : q[N-1]) : 1'b1;
    assign state_dbg = state;

    always_comb begin
        ctrl     = USR_HOLD;
        usr_d    = '0;
        state_nx = state;
        if (accept) begin
            ctrl     = USR_LOAD;
            usr_d    = mode ? '0 : tx_word;
            state_nx = mode ? ST_RX : ST_TX;
        end else if (busy && abort) begin
            state_nx = ST_IDLE;
        end else if (shift) begin
            ctrl  = LSB ? USR_SHR : USR_SHL;
            usr_d = LSB ? {in_bit, {(N-1){1'b0}}} : {{(N-1){1'b0}}, in_bit};
            if (last) begin
                state_nx = ST_IDLE;
            end
        end
    end

    usr #(.N(N)) u_usr (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl),
        .d    (usr_d),
        .q    (q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            rx_word  <= '0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= last;
            rx_valid <= last && (state == ST_RX);
            if (last && (state == ST_RX)) begin
                rx_word <= rx_shifted;
            end
            if (!busy || abort) begin
                div     <= '0;
                bit_cnt <= '0;
            end else if (div == DIV_LAST) begin
                div     <= '0;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
            end else begin
                div <= div + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_usr_serial_sequencer.sv
// Bench for usr_serial_sequencer: three instances (BIT_DIV/LSB_FIRST variants) checked
// every cycle against a job-level timeline model plus hand-computed literal expectations.
module tb_usr_serial_sequencer;

    localparam int N  = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         start_v[NI], mode_v[NI], abort_v[NI], rx_bit_v[NI];
    logic [N-1:0] tx_word_v[NI];
    logic         ready_v[NI], tx_bit_v[NI], done_v[NI], rx_valid_v[NI];
    logic [N-1:0] rx_word_v[NI];
    logic [1:0]   state_v[NI];

    int checks = 0;
    int errors = 0;

    // instance 0: BIT_DIV=1 LSB first, 1: BIT_DIV=1 MSB first, 2: BIT_DIV=3 LSB first
    function automatic int div_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic int pos_of(input int i, input int k);
        return (i == 1) ? (N - 1 - k) : k;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        usr_serial_sequencer #(
            .N         (N),
            .BIT_DIV   ((g == 2) ? 3 : 1),
            .LSB_FIRST ((g == 1) ? 0 : 1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .mode      (mode_v[g]),
            .tx_word   (tx_word_v[g]),
            .abort     (abort_v[g]),
            .rx_bit    (rx_bit_v[g]),
            .ready     (ready_v[g]),
            .tx_bit    (tx_bit_v[g]),
            .rx_word   (rx_word_v[g]),
            .done      (done_v[g]),
            .rx_valid  (rx_valid_v[g]),
            .state_dbg (state_v[g])
        );
    end

    task automatic chk(input string name, input int i, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Model: per instance, the cycle number t within the active job (1 = first cycle after
    // acceptance). Each job lasts N*BIT_DIV cycles; bit k occupies cycles k*D+1..(k+1)*D.
    bit           m_busy[NI], m_mode[NI], m_done[NI], m_rxv[NI];
    int           m_t[NI];
    logic [N-1:0] m_word[NI], m_acc[NI], m_rxw[NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 0; m_mode[i] = 0; m_done[i] = 0; m_rxv[i] = 0;
            m_t[i] = 0; m_word[i] = '0; m_acc[i] = '0; m_rxw[i] = '0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    m_busy[i] = 0; m_done[i] = 0; m_rxv[i] = 0;
                    m_t[i] = 0; m_acc[i] = '0; m_rxw[i] = '0;
                end else begin
                    m_done[i] = 0;
                    m_rxv[i]  = 0;
                    if (m_busy[i]) begin
                        if (abort_v[i]) begin
                            m_busy[i] = 0;
                        end else begin
                            if (m_mode[i] && (m_t[i] % div_of(i) == 0))
                                m_acc[i][pos_of(i, m_t[i] / div_of(i) - 1)] = rx_bit_v[i];
                            if (m_t[i] == N * div_of(i)) begin
                                m_busy[i] = 0;
                                m_done[i] = 1;
                                if (m_mode[i]) begin
                                    m_rxv[i] = 1;
                                    m_rxw[i] = m_acc[i];
                                end
                            end else begin
                                m_t[i]++;
                            end
                        end
                    end else if (start_v[i] && !abort_v[i]) begin
                        m_busy[i] = 1;
                        m_t[i]    = 1;
                        m_mode[i] = mode_v[i];
                        m_word[i] = tx_word_v[i];
                        m_acc[i]  = '0;
                    end
                end
            end
        end
    end

    function automatic logic exp_tx(input int i);
        if (m_busy[i] && !m_mode[i])
            return m_word[i][pos_of(i, (m_t[i] - 1) / div_of(i))];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk("cyc_ready",    i, N'(ready_v[i]),    N'(!m_busy[i]));
                chk("cyc_tx_bit",   i, N'(tx_bit_v[i]),   N'(exp_tx(i)));
                chk("cyc_done",     i, N'(done_v[i]),     N'(m_done[i]));
                chk("cyc_rx_valid", i, N'(rx_valid_v[i]), N'(m_rxv[i]));
                chk("cyc_rx_word",  i, rx_word_v[i],      m_rxw[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done_v[i] && cyc < 200);
        if (!done_v[i]) chk("done_timeout", i, '0, N'(1));
    endtask

    task automatic launch(input int i, input logic m, input logic [N-1:0] w);
        start_v[i]   = 1'b1;
        mode_v[i]    = m;
        tx_word_v[i] = w;
        tick();
        start_v[i] = 1'b0;
    endtask

    task automatic rx_job(input int i, input logic [N-1:0] w);
        launch(i, 1'b1, '0);
        for (int c = 1; c <= N * div_of(i); c++) begin
            rx_bit_v[i] = w[pos_of(i, (c - 1) / div_of(i))];
            tick();
        end
        chk("rx_job_done",  i, N'(done_v[i]),     N'(1));
        chk("rx_job_valid", i, N'(rx_valid_v[i]), N'(1));
        chk("rx_job_word",  i, rx_word_v[i],      w);
        tick();
    endtask

    initial begin
        int cyc;
        logic [N-1:0] pat;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 0; mode_v[i] = 0; abort_v[i] = 0; rx_bit_v[i] = 0; tx_word_v[i] = '0;
        end
        #2 rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready",   i, N'(ready_v[i]),  N'(1));
            chk("rst_tx_bit",  i, N'(tx_bit_v[i]), N'(1));
            chk("rst_done",    i, N'(done_v[i]),   N'(0));
            chk("rst_rx_word", i, rx_word_v[i],    '0);
        end
        rst = 1'b0;
        tick();

        // 1: LSB-first TX of 8'h01
        launch(0, 1'b0, 8'h01);
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) chk("t1_tx_bit", 0, N'(tx_bit_v[0]), N'(c == 1));
            chk("t1_done", 0, N'(done_v[0]), N'(c == 9));
            if (c < 9) tick();
        end
        tick();

        // 2: MSB-first TX of 8'h01
        launch(1, 1'b0, 8'h01);
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) chk("t2_tx_bit", 1, N'(tx_bit_v[1]), N'(c == 8));
            chk("t2_done", 1, N'(done_v[1]), N'(c == 9));
            if (c < 9) tick();
        end
        tick();

        // 3: BIT_DIV=3 RX, bits 1,1,0,1,0,0,1,0
        pat = 8'b0100_1011;
        launch(2, 1'b1, '0);
        for (int c = 1; c <= 24; c++) begin
            rx_bit_v[2] = pat[(c - 1) / 3];
            tick();
        end
        chk("t3_done",     2, N'(done_v[2]),     N'(1));
        chk("t3_rx_valid", 2, N'(rx_valid_v[2]), N'(1));
        chk("t3_rx_word",  2, rx_word_v[2],      8'h4B);
        chk("t3_model",    2, m_rxw[2],          8'h4B);
        tick();

        // 4: abort in cycle 4, then a clean TX
        launch(0, 1'b0, 8'hA5);
        tick(); tick(); tick();
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        chk("t4_ready",  0, N'(ready_v[0]),  N'(1));
        chk("t4_tx_bit", 0, N'(tx_bit_v[0]), N'(1));
        chk("t4_done",   0, N'(done_v[0]),   N'(0));
        tick(); tick();
        launch(0, 1'b0, 8'h3C);
        wait_done(0, cyc);
        chk("t4_latency", 0, N'(cyc), N'(8));
        tick();

        // 5: start held high; second word accepted in the done cycle
        start_v[0] = 1'b1; mode_v[0] = 1'b0; tx_word_v[0] = 8'h96;
        tick();
        tx_word_v[0] = 8'h69;
        wait_done(0, cyc);
        chk("t5_first_latency", 0, N'(cyc), N'(8));
        tick();
        start_v[0] = 1'b0;
        chk("t5_busy_again", 0, N'(ready_v[0]), N'(0));
        wait_done(0, cyc);
        chk("t5_second_latency", 0, N'(cyc), N'(8));
        tick();

        // 6: reset mid-RX, then a clean RX
        launch(2, 1'b1, '0);
        for (int c = 1; c <= 4; c++) begin
            rx_bit_v[2] = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        chk("t6_ready",    2, N'(ready_v[2]),    N'(1));
        chk("t6_rx_word",  2, rx_word_v[2],      '0);
        chk("t6_rx_valid", 2, N'(rx_valid_v[2]), N'(0));
        tick(); tick();
        rst = 1'b0;
        tick();
        rx_job(2, 8'hC3);

        // 7: abort in idle blocks start; MSB-first RX; BIT_DIV=3 TX
        start_v[0] = 1'b1; abort_v[0] = 1'b1; tx_word_v[0] = 8'hFF;
        tick();
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        chk("t7_idle_abort", 0, N'(ready_v[0]), N'(1));
        tick();
        rx_job(1, 8'hB1);
        launch(2, 1'b0, 8'h5C);
        wait_done(2, cyc);
        chk("t7_div3_latency", 2, N'(cyc), N'(24));
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
